// File: rtl/accum_axis_pkg.sv
// Shared widths, payload layout and helpers for the accumulator-to-AXIS packer.
package accum_axis_pkg;

  localparam int unsigned DATA_W = 48;
  localparam int unsigned SEQ_W  = 16;
  localparam int unsigned AXIS_W = DATA_W + SEQ_W;
  localparam int unsigned CNT_W  = 16;

  typedef logic [SEQ_W-1:0] seq_t;

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [DATA_W-1:0] data;
  } axis_word_t;

  // Saturating increment used by the drop counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with a registered head word; accepts a
// write while full when a read happens in the same cycle.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_full;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  logic             w_rd;
  logic             w_wr;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [LVL_W-1:0] w_level_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_rd         = rd_en && r_rd_valid;
  assign w_wr         = wr_en && (!r_full || w_rd);
  assign w_rd_ptr_nxt = w_rd ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
  assign w_level_nxt  = r_level + LVL_W'(w_wr) - LVL_W'(w_rd);
  // Incoming word bypasses storage when it becomes the new head.
  assign w_head_nxt   = (w_wr && (w_rd_ptr_nxt == r_wr_ptr)) ? wr_data : r_mem[w_rd_ptr_nxt];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_level    <= w_level_nxt;
      r_full     <= (w_level_nxt == LVL_W'(DEPTH));
      r_rd_valid <= (w_level_nxt != '0);
      if (w_level_nxt != '0) begin
        r_rd_data <= w_head_nxt;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign level    = r_level;
  assign full     = r_full;

endmodule

// File: rtl/accum_axis_packer.sv
// Tags accumulator results with a sequence number, buffers them and emits a framed
// 64-bit AXI4-Stream; counts results lost to a full buffer.
module accum_axis_packer
  import accum_axis_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PKT_LEN    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_in,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          clear,
  output logic [AXIS_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          overflow,
  output logic [CNT_W-1:0]              drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  logic              w_pop;
  logic              w_full;
  logic              w_accept;
  logic              w_drop;
  axis_word_t        w_wr_word;
  logic [BEAT_W-1:0] w_beat_nxt;

  seq_t              r_seq;
  logic [BEAT_W-1:0] r_beat;
  logic              r_beat_last;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_drop_count;

  assign w_pop      = m_axis_tvalid && m_axis_tready;
  assign w_accept   = valid_in && (!w_full || w_pop);
  assign w_drop     = valid_in && !w_accept;
  assign w_wr_word  = '{seq: r_seq, data: data_in};
  assign w_beat_nxt = r_beat_last ? '0 : r_beat + BEAT_W'(1);

  sync_fifo_fwft #(
    .WIDTH (AXIS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (w_accept),
    .wr_data  (w_wr_word),
    .rd_en    (m_axis_tready),
    .rd_data  (m_axis_tdata),
    .rd_valid (m_axis_tvalid),
    .level    (fifo_level),
    .full     (w_full)
  );

  // Sequence advances on every result, kept or dropped, so gaps expose losses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq <= '0;
    end else if (valid_in) begin
      r_seq <= r_seq + SEQ_W'(1);
    end
  end

  // Beat position within the current packet; last-beat flag kept as a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat      <= '0;
      r_beat_last <= (PKT_LEN == 1);
    end else if (w_pop) begin
      r_beat      <= w_beat_nxt;
      r_beat_last <= (w_beat_nxt == LAST_BEAT);
    end
  end

  // A drop in the same cycle as clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow   <= 1'b1;
      r_drop_count <= clear ? CNT_W'(1) : sat_inc(r_drop_count);
    end else if (clear) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign m_axis_tlast = r_beat_last && m_axis_tvalid;
  assign overflow     = r_overflow;
  assign drop_count   = r_drop_count;

endmodule
